// File: rtl/xgmii_rs_pkg.sv
// Shared encodings for the XGMII reconciliation-sublayer link-fault slice:
// link-fault codes, XGMII control characters, fault codes and FSM states.
package xgmii_rs_pkg;

  localparam logic [1:0] LF_OK     = 2'b00;
  localparam logic [1:0] LF_LOCAL  = 2'b01;
  localparam logic [1:0] LF_REMOTE = 2'b10;

  localparam logic [7:0] XGMII_IDLE = 8'h07;
  localparam logic [7:0] XGMII_SEQ  = 8'h9C;
  localparam logic [7:0] SEQ_LOCAL  = 8'h01;
  localparam logic [7:0] SEQ_REMOTE = 8'h02;

  // Full-width transmit patterns; lane 0 sits in the least significant byte.
  localparam logic [63:0] TX_IDLE_D = {8{XGMII_IDLE}};
  localparam logic [63:0] TX_RF_D   = {2{SEQ_REMOTE, 8'h00, 8'h00, XGMII_SEQ}};
  localparam logic [7:0]  TX_IDLE_C = 8'hFF;
  localparam logic [7:0]  TX_RF_C   = 8'h11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_COUNT,
    ST_FAULT
  } rs_state_e;

endpackage

// File: rtl/xgmii_fault_rs_if.sv
// Bus bundle for xgmii_fault_rs. Optional fault counters exist only when
// XGMII_FAULT_CNT_EN is defined.
interface xgmii_fault_rs_if;
  import xgmii_rs_pkg::*;

  // Streaming XGMII: no valid/ready, every signal is meaningful on every
  // clk156 edge; outputs are registered and present a new word each cycle.
  logic [63:0] rx_xgmii_d;
  logic [7:0]  rx_xgmii_c;
  logic [63:0] mac_txd;
  logic [7:0]  mac_txc;
  logic        pcs_lock;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [1:0]  link_fault;
  logic        link_up;
  rs_state_e   fsm_dbg;
`ifdef XGMII_FAULT_CNT_EN
  logic [15:0] local_fault_cnt;
  logic [15:0] remote_fault_cnt;
`endif

  modport master (
    output rx_xgmii_d, rx_xgmii_c, mac_txd, mac_txc, pcs_lock,
    input  xgmii_txd, xgmii_txc, link_fault, link_up, fsm_dbg
`ifdef XGMII_FAULT_CNT_EN
    , input local_fault_cnt, remote_fault_cnt
`endif
  );

  modport slave (
    input  rx_xgmii_d, rx_xgmii_c, mac_txd, mac_txc, pcs_lock,
    output xgmii_txd, xgmii_txc, link_fault, link_up, fsm_dbg
`ifdef XGMII_FAULT_CNT_EN
    , output local_fault_cnt, remote_fault_cnt
`endif
  );

endinterface

// File: rtl/xgmii_seq_decode.sv
// Decodes one 32-bit XGMII column into {is_seq, seq_type} for the
// local/remote fault ordered sets.
module xgmii_seq_decode
  import xgmii_rs_pkg::*;
(
  input  logic [31:0] col_d,
  input  logic [3:0]  col_c,
  output logic        is_seq,
  output logic [1:0]  seq_type
);

  logic [7:0] code;
  logic       frame_ok;

  always_comb begin
    code     = col_d[31:24];
    // Only lane 0 may be a control character; lanes 1-2 must be zero data.
    frame_ok = (col_c == 4'b0001) && (col_d[7:0] == XGMII_SEQ) &&
               (col_d[23:8] == 16'h0000);
    is_seq   = frame_ok && ((code == SEQ_LOCAL) || (code == SEQ_REMOTE));
    seq_type = LF_OK;
    if (is_seq) begin
      seq_type = (code == SEQ_LOCAL) ? LF_LOCAL : LF_REMOTE;
    end
  end

endmodule

// File: rtl/xgmii_fault_rs.sv
// Link-fault reconciliation sublayer: detects RX fault ordered sets, reports
// link_fault/link_up and overrides TX. XGMII_FAULT_CNT_EN adds fault counters.
module xgmii_fault_rs
  import xgmii_rs_pkg::*;
#(
  parameter int C_COL_WINDOW = 128,
  parameter int C_SEQ_THRESH = 4
) (
  input  logic             clk156,
  input  logic             reset,
  xgmii_fault_rs_if.slave  bus
);

  localparam logic [7:0] WIN = 8'(C_COL_WINDOW);
  localparam logic [3:0] TH  = 4'(C_SEQ_THRESH);

  logic       seq0, seq1;
  logic [1:0] type0, type1;

  xgmii_seq_decode u_dec0 (
    .col_d    (bus.rx_xgmii_d[31:0]),
    .col_c    (bus.rx_xgmii_c[3:0]),
    .is_seq   (seq0),
    .seq_type (type0)
  );

  xgmii_seq_decode u_dec1 (
    .col_d    (bus.rx_xgmii_d[63:32]),
    .col_c    (bus.rx_xgmii_c[7:4]),
    .is_seq   (seq1),
    .seq_type (type1)
  );

  rs_state_e   fsm_cs;
  logic [1:0]  seq_type;
  logic [3:0]  seq_cnt;
  logic [7:0]  col_cnt;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [63:0] txd_q;
  logic [7:0]  txc_q;

  logic [1:0] t_nxt;
  logic [3:0] c_nxt;
  logic [7:0] col_nxt;
  logic       any_seq, win_hit, thr_hit, new_fault;

  // Column 0 is older than column 1, so it is folded into the run first.
  always_comb begin
    t_nxt = seq_type;
    c_nxt = seq_cnt;
    if (seq0) begin
      if (type0 == t_nxt) c_nxt = (c_nxt >= TH) ? TH : c_nxt + 4'd1;
      else begin
        t_nxt = type0;
        c_nxt = 4'd1;
      end
    end
    if (seq1) begin
      if (type1 == t_nxt) c_nxt = (c_nxt >= TH) ? TH : c_nxt + 4'd1;
      else begin
        t_nxt = type1;
        c_nxt = 4'd1;
      end
    end
    if (seq1)                 col_nxt = 8'd0;
    else if (seq0)            col_nxt = 8'd1;
    else if (col_cnt > 8'd253) col_nxt = 8'd255;
    else                      col_nxt = col_cnt + 8'd2;
    any_seq   = seq0 | seq1;
    win_hit   = (col_nxt >= WIN);
    thr_hit   = (c_nxt >= TH);
    new_fault = thr_hit && !win_hit && (t_nxt != link_fault);
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      fsm_cs     <= ST_INIT;
      seq_type   <= LF_OK;
      seq_cnt    <= 4'd0;
      col_cnt    <= 8'd0;
      link_fault <= LF_OK;
      link_up    <= 1'b0;
      txd_q      <= TX_IDLE_D;
      txc_q      <= TX_IDLE_C;
    end else begin
      col_cnt <= col_nxt;
      link_up <= bus.pcs_lock && (link_fault == LF_OK);
      // Override follows the registered status, so it lags a change by one cycle.
      case (link_fault)
        LF_LOCAL: begin
          txd_q <= TX_RF_D;
          txc_q <= TX_RF_C;
        end
        LF_REMOTE: begin
          txd_q <= TX_IDLE_D;
          txc_q <= TX_IDLE_C;
        end
        default: begin
          txd_q <= bus.mac_txd;
          txc_q <= bus.mac_txc;
        end
      endcase
      case (fsm_cs)
        ST_INIT: begin
          if (any_seq) begin
            seq_type <= t_nxt;
            seq_cnt  <= c_nxt;
            if (thr_hit) begin
              fsm_cs     <= ST_FAULT;
              link_fault <= t_nxt;
            end else begin
              fsm_cs <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (thr_hit) begin
            fsm_cs     <= ST_FAULT;
            link_fault <= t_nxt;
            seq_type   <= t_nxt;
            seq_cnt    <= c_nxt;
          end else if (win_hit) begin
            fsm_cs   <= ST_INIT;
            seq_type <= LF_OK;
            seq_cnt  <= 4'd0;
          end else begin
            seq_type <= t_nxt;
            seq_cnt  <= c_nxt;
          end
        end
        ST_FAULT: begin
          if (win_hit) begin
            fsm_cs     <= ST_INIT;
            link_fault <= LF_OK;
            seq_type   <= LF_OK;
            seq_cnt    <= 4'd0;
          end else begin
            seq_type <= t_nxt;
            seq_cnt  <= c_nxt;
            if (thr_hit) link_fault <= t_nxt;
          end
        end
        default: fsm_cs <= ST_INIT;
      endcase
    end
  end

  assign bus.xgmii_txd  = txd_q;
  assign bus.xgmii_txc  = txc_q;
  assign bus.link_fault = link_fault;
  assign bus.link_up    = link_up;
  assign bus.fsm_dbg    = fsm_cs;

`ifdef XGMII_FAULT_CNT_EN
  logic [15:0] local_cnt, remote_cnt;

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      local_cnt  <= 16'd0;
      remote_cnt <= 16'd0;
    end else if (new_fault) begin
      if (t_nxt == LF_LOCAL && local_cnt != 16'hFFFF)   local_cnt  <= local_cnt + 16'd1;
      if (t_nxt == LF_REMOTE && remote_cnt != 16'hFFFF) remote_cnt <= remote_cnt + 16'd1;
    end
  end

  assign bus.local_fault_cnt  = local_cnt;
  assign bus.remote_fault_cnt = remote_cnt;
`endif

endmodule

// File: tb/tb_xgmii_fault_rs.sv
// Randomized scoreboard bench for xgmii_fault_rs against a column-level
// reference model; also checks asynchronous reset mid-fault.
`timescale 1ns/1ps
module tb_xgmii_fault_rs;
  import xgmii_rs_pkg::*;

  localparam int WIN = 128;
  localparam int TH  = 4;

  typedef struct packed {
    logic [1:0]  lf;
    logic        up;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [1:0]  st;
    logic [15:0] lcnt;
    logic [15:0] rcnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk156 = 1'b0;
  logic reset  = 1'b0;
  always #5 clk156 = ~clk156;

  xgmii_fault_rs_if bus ();

  xgmii_fault_rs #(.C_COL_WINDOW(WIN), .C_SEQ_THRESH(TH)) dut (
    .clk156 (clk156),
    .reset  (reset),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // ---------------- reference model state ----------------
  int         since;     // columns since the last fault sequence
  int         run_len;   // length of the current same-type run
  logic [1:0] run_type;
  logic [1:0] m_lf;
  int         m_lcnt, m_rcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    since = 0; run_len = 0; run_type = 2'b00; m_lf = 2'b00; m_lcnt = 0; m_rcnt = 0;
  endtask

  // Returns 00 for a non-sequence column, else 01 local / 10 remote.
  function automatic logic [1:0] col_kind(input logic [31:0] d, input logic [3:0] c);
    if (c != 4'b0001 || d[7:0] != 8'h9C || d[15:8] != 8'h00 || d[23:16] != 8'h00) return 2'b00;
    if (d[31:24] == 8'h01) return 2'b01;
    if (d[31:24] == 8'h02) return 2'b10;
    return 2'b00;
  endfunction

  // kind: 0 idle, 1 local seq, 2 remote seq, 3 random data, 4 near-miss
  function automatic logic [35:0] make_col(input int kind);
    logic [31:0] d;
    logic [3:0]  c;
    case (kind)
      1: begin d = 32'h0100009C; c = 4'b0001; end
      2: begin d = 32'h0200009C; c = 4'b0001; end
      3: begin d = $urandom; c = 4'b0000; end
      4: begin
        d = 32'h0100009C; c = 4'b0001;
        case ($urandom_range(0, 3))
          0: c = 4'b0000;
          1: d[15:8] = 8'($urandom_range(1, 255));
          2: d[31:24] = 8'h03;
          default: c = 4'b0011;
        endcase
      end
      default: begin d = 32'h07070707; c = 4'hF; end
    endcase
    return {c, d};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cols(input int k0, input int k1, input logic pcs);
    logic [35:0] c0, c1;
    logic [1:0]  kind, prev_lf;
    exp_t        e;
    c0 = make_col(k0);
    c1 = make_col(k1);
    @(negedge clk156);
    bus.rx_xgmii_d = {c1[31:0], c0[31:0]};
    bus.rx_xgmii_c = {c1[35:32], c0[35:32]};
    bus.mac_txd    = {$urandom, $urandom};
    bus.mac_txc    = 8'($urandom_range(0, 255));
    bus.pcs_lock   = pcs;
    prev_lf = m_lf;
    for (int i = 0; i < 2; i++) begin
      kind = (i == 0) ? col_kind(c0[31:0], c0[35:32]) : col_kind(c1[31:0], c1[35:32]);
      if (kind != 2'b00) begin
        since = 0;
        if (kind == run_type) run_len++;
        else begin run_type = kind; run_len = 1; end
      end else begin
        since++;
      end
    end
    if (since >= WIN) begin
      m_lf = 2'b00; run_len = 0; run_type = 2'b00;
    end else if (run_len >= TH && m_lf != run_type) begin
      m_lf = run_type;
      if (run_type == 2'b01) m_lcnt = (m_lcnt < 65535) ? m_lcnt + 1 : 65535;
      else                   m_rcnt = (m_rcnt < 65535) ? m_rcnt + 1 : 65535;
    end
    e.lf   = m_lf;
    e.up   = pcs && (prev_lf == 2'b00);
    e.txd  = (prev_lf == 2'b01) ? 64'h0200009C0200009C :
             (prev_lf == 2'b10) ? 64'h0707070707070707 : bus.mac_txd;
    e.txc  = (prev_lf == 2'b01) ? 8'h11 : (prev_lf == 2'b10) ? 8'hFF : bus.mac_txc;
    e.st   = (m_lf != 2'b00) ? ST_FAULT : (run_len > 0) ? ST_COUNT : ST_INIT;
    e.lcnt = 16'(m_lcnt);
    e.rcnt = 16'(m_rcnt);
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic pcs);
    for (int i = 0; i < n; i++) drive_cols(0, 0, pcs);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_link_fault"}, 64'(bus.link_fault), 64'h0);
    chk({tag, "_link_up"},    64'(bus.link_up),    64'h0);
    chk({tag, "_txd"},        bus.xgmii_txd,       64'h0707070707070707);
    chk({tag, "_txc"},        64'(bus.xgmii_txc),  64'hFF);
    chk({tag, "_fsm"},        64'(bus.fsm_dbg),    64'(ST_INIT));
`ifdef XGMII_FAULT_CNT_EN
    chk({tag, "_lcnt"},       64'(bus.local_fault_cnt),  64'h0);
    chk({tag, "_rcnt"},       64'(bus.remote_fault_cnt), 64'h0);
`endif
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk156) begin
    #1;
    if (mon_en && !reset) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 64'(exp_q.size()), 64'h1);
      end else begin
        exp_t e;
        e = exp_t'(exp_q.pop_front());
        chk("link_fault", 64'(bus.link_fault), 64'(e.lf));
        chk("link_up",    64'(bus.link_up),    64'(e.up));
        chk("xgmii_txd",  bus.xgmii_txd,       e.txd);
        chk("xgmii_txc",  64'(bus.xgmii_txc),  64'(e.txc));
        chk("fsm_state",  64'(bus.fsm_dbg),    64'(e.st));
`ifdef XGMII_FAULT_CNT_EN
        chk("local_cnt",  64'(bus.local_fault_cnt),  64'(e.lcnt));
        chk("remote_cnt", 64'(bus.remote_fault_cnt), 64'(e.rcnt));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dens, len, k0, k1;
    bus.rx_xgmii_d = 64'h0707070707070707;
    bus.rx_xgmii_c = 8'hFF;
    bus.mac_txd    = 64'h0;
    bus.mac_txc    = 8'h0;
    bus.pcs_lock   = 1'b0;
    model_reset();

    #1 reset = 1'b1;
    #1 check_reset_values("por");
    repeat (3) @(negedge clk156);
    reset = 1'b0;

    // Idles with pcs_lock toggling: link_up tracks pcs_lock one cycle later.
    for (int i = 0; i < 8; i++) drive_cols(0, 0, 1'($urandom_range(0, 1)));
    // Local fault in two cycles, then TX override.
    drive_cols(1, 1, 1'b1);
    drive_cols(1, 1, 1'b1);
    idle_cycles(3, 1'b1);
    // Switch local -> remote without passing through OK.
    drive_cols(2, 2, 1'b1);
    drive_cols(2, 2, 1'b1);
    // Sequences stop: status clears after the window.
    idle_cycles(66, 1'b1);
    // Three remote sequences are below threshold, then window expiry.
    drive_cols(2, 2, 1'b1);
    drive_cols(2, 0, 1'b1);
    idle_cycles(66, 1'b1);
    // Near-miss columns must never count.
    for (int i = 0; i < 12; i++) drive_cols(4, 4, 1'b1);

    // Randomized segments with varying sequence density.
    for (int s = 0; s < 25; s++) begin
      dens = $urandom_range(0, 2);
      len  = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        k0 = (dens == 0 || $urandom_range(0, (dens == 1) ? 7 : 1) != 0) ?
             (($urandom_range(0, 1) != 0) ? 3 : 0) : $urandom_range(1, 2);
        k1 = (dens == 0 || $urandom_range(0, (dens == 1) ? 7 : 1) != 0) ?
             (($urandom_range(0, 5) == 0) ? 4 : 0) : $urandom_range(1, 2);
        drive_cols(k0, k1, 1'($urandom_range(0, 3) != 0));
      end
    end

    // Establish a local fault, then assert reset between clock edges.
    drive_cols(1, 1, 1'b1);
    drive_cols(1, 1, 1'b1);
    drive_cols(0, 0, 1'b1);
    @(posedge clk156);
    #2;
    mon_en = 1'b0;
    chk("pre_reset_fault", 64'(bus.link_fault), 64'h1);
    chk("queue_drained_1", 64'(exp_q.size()), 64'h0);
    reset = 1'b1;
    #1 check_reset_values("mid_fault");
    @(negedge clk156);
    reset = 1'b0;
    exp_q.delete();
    model_reset();

    for (int i = 0; i < 20; i++) drive_cols($urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
    @(posedge clk156);
    #3;
    chk("queue_drained_2", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
